spfp_div_result_stage: RTL
==========================

Name: spfp_div_result_stage

Overview:
Registered post-processing stage directly downstream of the SPFP divider. It captures the operands and the divider's raw quotient, which is only valid for normal, in-range operands. It then applies IEEE-754 special-case and range handling, producing the final quotient and exception flags. It adds a 2-deep valid/ready pipeline and sticky flag accumulation for the ALU status logic.

Parameters:
DEFAULT_NAN, 32'h7FC0_0000, quiet NaN returned for every NaN result.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/quotient set presented
in_ready  output  1  stage can accept this cycle
n1  input  32  dividend, as fed to the divider
n2  input  32  divisor, as fed to the divider
q_raw  input  32  divider output for the same n1/n2, same cycle
out_valid  output  1  z/flags valid
out_ready  input  1  consumer accepts this cycle
z  output  32  final quotient
flags  output  4  {nv, dz, of, uf} for the result on z
flag_clr  input  1  clear sticky flags
flags_sticky  output  4  OR of flags of all fired results since reset or clear

Behaviour:
- Reset (rst=1 at a clock edge): both pipeline stages are emptied. Outputs read out_valid=0, z=0, flags=0 and flags_sticky=0. in_ready=1 in the following cycle. Any in-flight data is discarded.
- Accept: accept occurs when in_valid && in_ready. Fire occurs when out_valid && out_ready.
- Pipeline structure:
  - S1 registers the operand classification, the signs, e_exp and q_raw.
  - S2 registers the final z and flags. S2 drives out_valid, z and flags directly from registers.
- Flow control:
  - S2 loads from S1 when S1 is valid and (S2 is empty or out_ready=1).
  - in_ready = !s1_valid || (S2 empty || out_ready). This is a combinational path from out_ready, which is permitted.
  - Simultaneous accept and advance in the same cycle is supported, giving one result per cycle at full throughput.
- Latency: 2 cycles. Data accepted at edge k gives out_valid=1 after edge k+1.
- Order is preserved. No entry is dropped or duplicated under any out_ready pattern. z and flags are held stable while out_valid=1 and out_ready=0.
- Classification, per operand, from exponent e and fraction f:
  - zero: e=0. Subnormals are treated as zero (DAZ), consistent with the divider.
  - inf: e=255, f=0.
  - qNaN: e=255, f[22]=1.
  - sNaN: e=255, f!=0, f[22]=0.
  - normal: otherwise.
- Result rules (s = n1[31]^n2[31]), applied in priority order:
  1. Either operand NaN: z=DEFAULT_NAN. nv=1 only if either operand is sNaN.
  2. inf/inf or zero/zero: z=DEFAULT_NAN, nv=1.
  3. inf/(normal or zero): z={s,8'hFF,23'h0}.
  4. normal/inf or zero/inf: z={s,31'h0}.
  5. normal/zero: z={s,8'hFF,23'h0}, dz=1.
  6. zero/normal: z={s,31'h0}.
  7. normal/normal: compute the expected exponent e_exp, a 10-bit signed value:
     - e_exp = n1[30:23] - n2[30:23] + 127 - (m1<m2), where m = {1,f}.
     - e_exp >= 255: z={s,8'hFF,23'h0}, of=1.
     - e_exp <= 0: z={s,31'h0}, uf=1 (flush to zero).
     - Otherwise: z={s,q_raw[30:0]}, flags=0.
- Sticky flags update every cycle: flags_sticky <= (flag_clr ? 0 : flags_sticky) | (fire ? flags : 0).
  - When flag_clr and fire occur in the same cycle, the fired result's flags survive.
  - rst overrides flag_clr.

Test Plan:
- 6.0/2.0: n1=40C00000, n2=40000000, q_raw=40400000, out_ready=1 -> z=40400000, flags=0, out_valid exactly 2 cycles after accept; q_raw=C0400000 with n1=C0C00000 -> z=C0400000.
- Specials: 3F800000/00000000 -> z=7F800000, dz=1. 00000000/00000000 -> 7FC00000, nv=1. 7F800000/7F800000 -> 7FC00000, nv=1. 7F800001/3F800000 -> 7FC00000, nv=1. 7FC00001/3F800000 -> 7FC00000, flags=0. 3F800000/FF800000 -> 80000000.
- Range: 7F000000/00800000 -> e_exp=380, z=7F800000, of=1. 00800000/7F000000 -> z=00000000, uf=1. 3F800000/3FC00000 (m1<m2) -> passes {0,q_raw[30:0]}.
- Backpressure: 4 back-to-back accepts with out_ready=0 -> in_ready drops after 2 accepted; the 2 pending are held stable. out_ready=1 -> results emerge in order, one per cycle, and the remaining inputs are accepted without loss.
- Sticky: fire dz result, then of result -> flags_sticky=4'b0110. flag_clr with a simultaneous uf fire -> 4'b0001. flag_clr alone -> 0.
- Reset mid-operation: rst with both stages full and out_ready=0 -> next cycle out_valid=0, z=0, flags=0, flags_sticky=0, in_ready=1. The next accept produces a correct result 2 cycles later.

Source files
------------

// File: rtl/spfp_div_result_stage.sv
// Result stage behind the SPFP divider: classifies the operands, applies
// IEEE-754 special-case and exponent-range handling to the raw quotient, and
// presents the final quotient and exception flags through a 2-deep valid/ready
// pipeline. Sticky flags accumulate for the ALU status logic.
module spfp_div_result_stage #(
   parameter logic [31:0] DEFAULT_NAN = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] n1,
   input  logic [31:0] n2,
   input  logic [31:0] q_raw,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] z,
   output logic [3:0]  flags,
   input  logic        flag_clr,
   output logic [3:0]  flags_sticky
);

   logic [7:0]  e1, e2;
   logic [22:0] f1, f2;
   logic        zero1_d, inf1_d, nan1_d, snan1_d;
   logic        zero2_d, inf2_d, nan2_d, snan2_d;
   logic        m_lt;
   logic [9:0]  eexp_d;

   logic        s1_valid_q;
   logic        s1_sign_q;
   logic        s1_zero1_q, s1_inf1_q, s1_nan1_q, s1_snan1_q;
   logic        s1_zero2_q, s1_inf2_q, s1_nan2_q, s1_snan2_q;
   logic [9:0]  s1_eexp_q;
   logic [30:0] s1_qraw_q;

   logic        s2_valid_q;
   logic [31:0] s2_z_q, s2_z_d;
   logic [3:0]  s2_flags_q, s2_flags_d;
   logic [3:0]  sticky_q, sticky_d;

   logic        accept, advance, fire;

   assign e1 = n1[30:23];
   assign e2 = n2[30:23];
   assign f1 = n1[22:0];
   assign f2 = n2[22:0];

   assign accept   = in_valid && in_ready;
   assign advance  = s1_valid_q && (!s2_valid_q || out_ready);
   assign fire     = s2_valid_q && out_ready;
   assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;

   // Operand classification and expected exponent; subnormals count as zero.
   always_comb begin
      zero1_d = (e1 == 8'h00);
      inf1_d  = (e1 == 8'hFF) && (f1 == 23'h0);
      nan1_d  = (e1 == 8'hFF) && (f1 != 23'h0);
      snan1_d = nan1_d && !f1[22];
      zero2_d = (e2 == 8'h00);
      inf2_d  = (e2 == 8'hFF) && (f2 == 23'h0);
      nan2_d  = (e2 == 8'hFF) && (f2 != 23'h0);
      snan2_d = nan2_d && !f2[22];
      // Both mantissas carry the same hidden 1, so comparing fractions suffices.
      m_lt    = (f1 < f2);
      eexp_d  = {2'b00, e1} - {2'b00, e2} + 10'd127 - {9'd0, m_lt};
   end

   // S1: capture classification, sign, expected exponent and raw quotient.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_zero1_q <= 1'b0;
         s1_inf1_q  <= 1'b0;
         s1_nan1_q  <= 1'b0;
         s1_snan1_q <= 1'b0;
         s1_zero2_q <= 1'b0;
         s1_inf2_q  <= 1'b0;
         s1_nan2_q  <= 1'b0;
         s1_snan2_q <= 1'b0;
         s1_eexp_q  <= 10'd0;
         s1_qraw_q  <= 31'd0;
      end else begin
         if (accept) begin
            s1_valid_q <= 1'b1;
            s1_sign_q  <= n1[31] ^ n2[31];
            s1_zero1_q <= zero1_d;
            s1_inf1_q  <= inf1_d;
            s1_nan1_q  <= nan1_d;
            s1_snan1_q <= snan1_d;
            s1_zero2_q <= zero2_d;
            s1_inf2_q  <= inf2_d;
            s1_nan2_q  <= nan2_d;
            s1_snan2_q <= snan2_d;
            s1_eexp_q  <= eexp_d;
            s1_qraw_q  <= q_raw[30:0];
         end else if (advance) begin
            s1_valid_q <= 1'b0;
         end
      end
   end

   // Special-case and range resolution, in priority order.
   always_comb begin
      s2_z_d     = {s1_sign_q, s1_qraw_q};
      s2_flags_d = 4'b0000;
      if (s1_nan1_q || s1_nan2_q) begin
         s2_z_d        = DEFAULT_NAN;
         s2_flags_d[3] = s1_snan1_q || s1_snan2_q;
      end else if ((s1_inf1_q && s1_inf2_q) || (s1_zero1_q && s1_zero2_q)) begin
         s2_z_d     = DEFAULT_NAN;
         s2_flags_d = 4'b1000;
      end else if (s1_inf1_q) begin
         s2_z_d = {s1_sign_q, 8'hFF, 23'h0};
      end else if (s1_inf2_q) begin
         s2_z_d = {s1_sign_q, 31'h0};
      end else if (s1_zero2_q) begin
         s2_z_d     = {s1_sign_q, 8'hFF, 23'h0};
         s2_flags_d = 4'b0100;
      end else if (s1_zero1_q) begin
         s2_z_d = {s1_sign_q, 31'h0};
      end else if ($signed(s1_eexp_q) >= 10'sd255) begin
         s2_z_d     = {s1_sign_q, 8'hFF, 23'h0};
         s2_flags_d = 4'b0010;
      end else if ($signed(s1_eexp_q) <= 10'sd0) begin
         s2_z_d     = {s1_sign_q, 31'h0};
         s2_flags_d = 4'b0001;
      end
   end

   // Fired flags survive a simultaneous clear.
   always_comb begin
      sticky_d = (flag_clr ? 4'b0000 : sticky_q) | (fire ? s2_flags_q : 4'b0000);
   end

   // S2: output register, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_z_q     <= 32'd0;
         s2_flags_q <= 4'd0;
         sticky_q   <= 4'd0;
      end else begin
         sticky_q <= sticky_d;
         if (advance) begin
            s2_valid_q <= 1'b1;
            s2_z_q     <= s2_z_d;
            s2_flags_q <= s2_flags_d;
         end else if (fire) begin
            s2_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid    = s2_valid_q;
   assign z            = s2_z_q;
   assign flags        = s2_flags_q;
   assign flags_sticky = sticky_q;

endmodule
